// File: rtl/bsg_mcl_fifo_width_adapter_if.sv
// -----------------------------------------------------------------------------
// bsg_mcl_fifo_width_adapter_if
//
// Groups the per-channel handshake and data buses of the width adapter.
// Every field is num_channels_p wide, or num_channels_p words wide, with
// channel c in the c-th slice.
//
//   Host -> manycore : host_tx_v_i / host_tx_data_i / host_tx_ready_o
//                      mc_tx_v_o   / mc_tx_data_o   / mc_tx_ready_i
//   Manycore -> host : mc_rx_v_i   / mc_rx_data_i   / mc_rx_ready_o
//                      host_rx_v_o / host_rx_data_o / host_rx_yumi_i
//   Status           : rx_vacancy_o (free rx packet slots),
//                      tx_words_o   (words held in the tx collector)
//
// Modports:
//   slave  - the adapter itself.
//   master - the surrounding logic: host FIFOs and the manycore endpoint.
// -----------------------------------------------------------------------------
interface bsg_mcl_fifo_width_adapter_if #(
    parameter int num_channels_p = 2,
    parameter int host_width_p   = 32,
    parameter int pkt_width_p    = 128,
    parameter int rcv_fifo_els_p = 4
);
    localparam int els_lp   = pkt_width_p / host_width_p;
    localparam int cnt_w_lp = $clog2(els_lp + 1);
    localparam int vac_w_lp = $clog2(rcv_fifo_els_p + 1);

    logic [num_channels_p-1:0]                host_tx_v_i;
    logic [num_channels_p*host_width_p-1:0]   host_tx_data_i;
    logic [num_channels_p-1:0]                host_tx_ready_o;
    logic [num_channels_p-1:0]                mc_tx_v_o;
    logic [num_channels_p*pkt_width_p-1:0]    mc_tx_data_o;
    logic [num_channels_p-1:0]                mc_tx_ready_i;
    logic [num_channels_p-1:0]                mc_rx_v_i;
    logic [num_channels_p*pkt_width_p-1:0]    mc_rx_data_i;
    logic [num_channels_p-1:0]                mc_rx_ready_o;
    logic [num_channels_p-1:0]                host_rx_v_o;
    logic [num_channels_p*host_width_p-1:0]   host_rx_data_o;
    logic [num_channels_p-1:0]                host_rx_yumi_i;
    logic [num_channels_p*vac_w_lp-1:0]       rx_vacancy_o;
    logic [num_channels_p*cnt_w_lp-1:0]       tx_words_o;

    modport slave (
        input  host_tx_v_i, host_tx_data_i, mc_tx_ready_i,
        input  mc_rx_v_i, mc_rx_data_i, host_rx_yumi_i,
        output host_tx_ready_o, mc_tx_v_o, mc_tx_data_o,
        output mc_rx_ready_o, host_rx_v_o, host_rx_data_o,
        output rx_vacancy_o, tx_words_o
    );

    modport master (
        output host_tx_v_i, host_tx_data_i, mc_tx_ready_i,
        output mc_rx_v_i, mc_rx_data_i, host_rx_yumi_i,
        input  host_tx_ready_o, mc_tx_v_o, mc_tx_data_o,
        input  mc_rx_ready_o, host_rx_v_o, host_rx_data_o,
        input  rx_vacancy_o, tx_words_o
    );
endinterface

// File: rtl/bsg_mcl_fifo_width_adapter.sv
// -----------------------------------------------------------------------------
// bsg_mcl_fifo_width_adapter
//
// Per-channel width adapter between host-side narrow word FIFOs and
// manycore-endpoint packet FIFOs. Each channel is fully independent.
//
//   tx: els_lp host words are collected into a packet register, which is
//       then offered to the endpoint. The collector takes no word in the
//       cycle a packet leaves, so a packet takes els_lp+1 cycles.
//   rx: packets land in a rcv_fifo_els_p-deep FIFO. The head is serialised
//       straight out of FIFO storage, one host word per yumi. A slot is
//       freed only when the last word of the packet has been consumed.
//
// Ports:
//   clk_i, reset_n_i  clock, asynchronous active-low reset
//   flush_i [C]       per-channel flush: empties the tx collector and
//                     rewinds the rx head to word 0
//   bus (slave)       handshake, data and status buses
//                     (see bsg_mcl_fifo_width_adapter_if)
//   stats_o [C*64]    only when BSG_MCL_ADAPTER_STATS_EN is defined.
//                     Channel c uses bits [c*64 +: 32] for tx packets sent
//                     and [c*64+32 +: 32] for rx packets drained.
//
// Word order: lsw_first_p=1 puts word k at packet bits
// [k*host_width_p +: host_width_p]. lsw_first_p=0 puts it in slot els_lp-1-k.
// -----------------------------------------------------------------------------
module bsg_mcl_fifo_width_adapter #(
    parameter int num_channels_p = 2,
    parameter int host_width_p   = 32,
    parameter int pkt_width_p    = 128,
    parameter int rcv_fifo_els_p = 4,
    parameter bit lsw_first_p    = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [num_channels_p-1:0] flush_i,
    bsg_mcl_fifo_width_adapter_if.slave bus
`ifdef BSG_MCL_ADAPTER_STATS_EN
    ,
    output logic [num_channels_p*64-1:0] stats_o
`endif
);
    localparam int els_lp   = pkt_width_p / host_width_p;
    localparam int cnt_w_lp = $clog2(els_lp + 1);
    localparam int vac_w_lp = $clog2(rcv_fifo_els_p + 1);
    localparam int idx_w_lp = (els_lp > 1) ? $clog2(els_lp) : 1;
    localparam int ptr_w_lp = $clog2(rcv_fifo_els_p);

    typedef enum logic {
        COLLECT_S = 1'b0,
        FULL_S    = 1'b1
    } tx_state_e;

    // Wraps at rcv_fifo_els_p, so the depth need not be a power of two.
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(rcv_fifo_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    for (genvar ch = 0; ch < num_channels_p; ch++) begin : g_ch

        // ------------------------------- tx ---------------------------------
        tx_state_e             tx_state_r;
        logic [cnt_w_lp-1:0]   tx_cnt_r;
        logic [host_width_p-1:0] tx_slot_r [els_lp];
        logic [idx_w_lp-1:0]   tx_wr_slot;
        logic                  tx_accept;
        logic                  tx_send;

        assign tx_accept = bus.host_tx_v_i[ch] & (tx_state_r == COLLECT_S);
        assign tx_send   = bus.mc_tx_ready_i[ch] & (tx_state_r == FULL_S);

        // NOTE: give every always_comb output a default first, so a missed
        // branch cannot infer a latch.
        always_comb begin
            tx_wr_slot = idx_w_lp'(tx_cnt_r);
            if (!lsw_first_p) tx_wr_slot = idx_w_lp'(els_lp - 1) - idx_w_lp'(tx_cnt_r);
        end

        // The state register drives ready/valid directly, so mc_tx_v_o has no
        // combinational path from host_tx_v_i. Flush wins over a concurrent
        // send: the packet counts as delivered, and any word offered is dropped.
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before the edge.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                tx_state_r <= COLLECT_S;
                tx_cnt_r   <= '0;
            end else if (flush_i[ch]) begin
                tx_state_r <= COLLECT_S;
                tx_cnt_r   <= '0;
            end else if (tx_send) begin
                tx_state_r <= COLLECT_S;
                tx_cnt_r   <= '0;
            end else if (tx_accept) begin
                tx_cnt_r <= tx_cnt_r + cnt_w_lp'(1);
                if (tx_cnt_r == cnt_w_lp'(els_lp - 1)) tx_state_r <= FULL_S;
            end
        end

        // NOTE: data storage has no reset. Valid qualifiers guard every read,
        // so clearing the payload would only cost reset routing.
        always_ff @(posedge clk_i) begin
            if (tx_accept & ~flush_i[ch])
                tx_slot_r[tx_wr_slot] <= bus.host_tx_data_i[ch*host_width_p +: host_width_p];
        end

        for (genvar s = 0; s < els_lp; s++) begin : g_tx_slot
            assign bus.mc_tx_data_o[(ch*els_lp + s)*host_width_p +: host_width_p] = tx_slot_r[s];
        end

        assign bus.host_tx_ready_o[ch]              = (tx_state_r == COLLECT_S);
        assign bus.mc_tx_v_o[ch]                    = (tx_state_r == FULL_S);
        assign bus.tx_words_o[ch*cnt_w_lp +: cnt_w_lp] = tx_cnt_r;

        // ------------------------------- rx ---------------------------------
        logic [pkt_width_p-1:0]  rx_mem_r [rcv_fifo_els_p];
        logic [ptr_w_lp-1:0]     rx_wr_ptr_r;
        logic [ptr_w_lp-1:0]     rx_rd_ptr_r;
        logic [vac_w_lp-1:0]     rx_cnt_r;
        logic [idx_w_lp-1:0]     rx_idx_r;
        logic [idx_w_lp-1:0]     rx_rd_slot;
        logic [host_width_p-1:0] rx_head_words [els_lp];
        logic                    rx_full;
        logic                    rx_empty;
        logic                    rx_last;
        logic                    rx_enq;
        logic                    rx_deq;

        assign rx_full  = (rx_cnt_r == vac_w_lp'(rcv_fifo_els_p));
        assign rx_empty = (rx_cnt_r == '0);
        assign rx_last  = (rx_idx_r == idx_w_lp'(els_lp - 1));
        assign rx_enq   = bus.mc_rx_v_i[ch] & ~rx_full;
        // A flush rewinds the head instead of retiring it, even on its last word.
        assign rx_deq   = bus.host_rx_yumi_i[ch] & rx_last & ~flush_i[ch] & ~rx_empty;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                rx_wr_ptr_r <= '0;
                rx_rd_ptr_r <= '0;
                rx_cnt_r    <= '0;
                rx_idx_r    <= '0;
            end else begin
                if (rx_enq) rx_wr_ptr_r <= ptr_inc(rx_wr_ptr_r);
                if (rx_deq) rx_rd_ptr_r <= ptr_inc(rx_rd_ptr_r);
                if (rx_enq & ~rx_deq)      rx_cnt_r <= rx_cnt_r + vac_w_lp'(1);
                else if (~rx_enq & rx_deq) rx_cnt_r <= rx_cnt_r - vac_w_lp'(1);
                if (flush_i[ch])                  rx_idx_r <= '0;
                else if (bus.host_rx_yumi_i[ch])  rx_idx_r <= rx_last ? '0 : rx_idx_r + idx_w_lp'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (rx_enq) rx_mem_r[rx_wr_ptr_r] <= bus.mc_rx_data_i[ch*pkt_width_p +: pkt_width_p];
        end

        for (genvar s = 0; s < els_lp; s++) begin : g_rx_word
            assign rx_head_words[s] = rx_mem_r[rx_rd_ptr_r][s*host_width_p +: host_width_p];
        end

        always_comb begin
            rx_rd_slot = rx_idx_r;
            if (!lsw_first_p) rx_rd_slot = idx_w_lp'(els_lp - 1) - rx_idx_r;
        end

        assign bus.mc_rx_ready_o[ch] = ~rx_full;
        assign bus.host_rx_v_o[ch]   = ~rx_empty;
        assign bus.host_rx_data_o[ch*host_width_p +: host_width_p] = rx_head_words[rx_rd_slot];
        assign bus.rx_vacancy_o[ch*vac_w_lp +: vac_w_lp] = vac_w_lp'(rcv_fifo_els_p) - rx_cnt_r;

        // The host may only consume a word that is being presented.
        a_yumi_needs_valid: assert property (
            @(posedge clk_i) disable iff (!reset_n_i) bus.host_rx_yumi_i[ch] |-> !rx_empty
        );

`ifdef BSG_MCL_ADAPTER_STATS_EN
        logic [31:0] stat_tx_r;
        logic [31:0] stat_rx_r;

        // Flush does not clear these counters. A send during flush still counts.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                stat_tx_r <= '0;
                stat_rx_r <= '0;
            end else begin
                if (tx_send) stat_tx_r <= stat_tx_r + 32'd1;
                if (rx_deq)  stat_rx_r <= stat_rx_r + 32'd1;
            end
        end

        assign stats_o[ch*64 +: 32]      = stat_tx_r;
        assign stats_o[ch*64 + 32 +: 32] = stat_rx_r;
`endif
    end

endmodule

// File: doc/bsg_mcl_fifo_width_adapter.md
Name: bsg_mcl_fifo_width_adapter

Overview:
Parametrised per-channel width adapter between host-side narrow word FIFOs and manycore-endpoint packet FIFOs. It generalises the fixed 32-bit/2-slot serdes arrangement to:
- arbitrary host word width, packet width and channel count;
- selectable word order;
- an integrated receive buffer with an exact vacancy count;
- a per-channel flush.

It sits between the AXIL-to-FIFO slot logic and the endpoint-to-FIFO block.

Parameters:
num_channels_p, 2, number of independent channels (>=1)
host_width_p, 32, host-side word width in bits
pkt_width_p, 128, manycore FIFO packet width; must be an integer multiple of host_width_p
rcv_fifo_els_p, 4, receive packet buffer depth per channel (>=2)
lsw_first_p, 1, 1: word k maps to packet bits [k*host_width_p +: host_width_p]; 0: word k maps to word slot (els-1-k)
(derived) els_lp = pkt_width_p/host_width_p; cnt_w_lp = clog2(els_lp+1); vac_w_lp = clog2(rcv_fifo_els_p+1)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
flush_i  in  C  per-channel flush pulse
host_tx_v_i  in  C  host word valid (host -> manycore)
host_tx_data_i  in  C*host_width_p  host word
host_tx_ready_o  out  C  collector can accept a word
mc_tx_v_o  out  C  complete packet valid
mc_tx_data_o  out  C*pkt_width_p  assembled packet
mc_tx_ready_i  in  C  endpoint accepts packet
mc_rx_v_i  in  C  packet from endpoint valid
mc_rx_data_i  in  C*pkt_width_p  packet from endpoint
mc_rx_ready_o  out  C  receive buffer not full
host_rx_v_o  out  C  host word valid (manycore -> host)
host_rx_data_o  out  C*host_width_p  host word
host_rx_yumi_i  in  C  host consumes word
rx_vacancy_o  out  C*vac_w_lp  free packet slots in receive buffer
tx_words_o  out  C*cnt_w_lp  words held in collector

Behaviour:
- Reset (asynchronous assert, clk_i-synchronous deassert):
  - tx word counter = 0 and rx word index = 0; receive FIFO empty.
  - Outputs: host_tx_ready_o = all 1; mc_tx_v_o = 0; mc_rx_ready_o = all 1; host_rx_v_o = 0; rx_vacancy_o = rcv_fifo_els_p; tx_words_o = 0.
  - Reset mid-packet discards all partial and buffered data.
- Tx collector, per channel:
  - States: COLLECT while cnt < els_lp; FULL when cnt == els_lp.
  - host_tx_ready_o = (cnt != els_lp).
  - On host_tx_v_i & host_tx_ready_o, the word is written into its slot (per lsw_first_p) and cnt increments. The slot register updates in the same cycle.
  - mc_tx_v_o = (cnt == els_lp), registered, with no combinational path from host_tx_v_i. mc_tx_data_o is stable while valid.
  - On mc_tx_v_o & mc_tx_ready_i: cnt -> 0. No word is accepted in that cycle, so throughput is one packet per els_lp+1 cycles.
- Rx path, per channel:
  - A 1r1w FIFO of rcv_fifo_els_p packets; mc_rx_ready_o = !full (valid-then-ready; mc_rx_v_i must not depend on mc_rx_ready_o).
  - The serializer reads the FIFO head directly. host_rx_v_o = !empty. host_rx_data_o = head word at index idx (per lsw_first_p).
  - On host_rx_yumi_i: idx increments. When idx == els_lp-1, idx -> 0 and the head is dequeued.
  - host_rx_yumi_i asserted while host_rx_v_o = 0 is illegal and is asserted in simulation.
- rx_vacancy_o = rcv_fifo_els_p - occupancy:
  - A packet counts as occupied until its last word is yumi'd.
  - Simultaneous enqueue and final-word dequeue leaves vacancy unchanged.
  - Enqueue into a full FIFO cannot occur, because ready = 0.
- els_lp == 1: every word is a packet; the same registered timing applies.
- Flush, synchronous, per channel:
  - Tx: cnt -> 0 and mc_tx_v_o drops next cycle. A word accepted in the flush cycle is discarded; flush wins over a concurrent mc_tx handshake. If mc_tx_ready_i was high in that cycle, the packet is treated as delivered.
  - Rx: idx -> 0, so the head packet is replayed from word 0. Buffered packets are kept and the vacancy count is unchanged.
- Channels are fully independent, with no shared arbitration.

Optional Feature:
- Macro: BSG_MCL_ADAPTER_STATS_EN.
- When defined:
  - Adds output stats_o [C*2*32]: per channel, a tx packet count and an rx packet count.
  - Tx count increments on each mc_tx handshake; rx count increments on each final-word dequeue.
  - Counters wrap at 2^32, reset to 0, and are not cleared by flush_i.
- When undefined: the port and counters are absent, with no other behaviour change.

Test Plan:
- Single packet, host->mc: C=2, els=4, lsw_first_p=1. Drive words 0x11,0x22,0x33,0x44 on ch0 back-to-back -> tx_words_o steps 1..4 and host_tx_ready_o goes 0 on cnt=4. mc_tx_v_o rises the cycle after the 4th word with data 0x00000044_00000033_00000022_00000011. Ch1 stays idle.
- Word order: lsw_first_p=0, same stimulus -> mc_tx_data_o = 0x00000011_00000022_00000033_00000044.
- Rx buffering and vacancy: rcv_fifo_els_p=4. Push 4 packets with host_rx_yumi_i=0 -> rx_vacancy_o 4,3,2,1,0 and mc_rx_ready_o = 0. Yumi 4 words -> vacancy returns to 1 only after the 4th word. Enqueue and final yumi in the same cycle -> vacancy held.
- Flush mid-packet: after 2 tx words, pulse flush_i[0] together with a 3rd valid word -> tx_words_o = 0 and no mc_tx_v_o. Rx: after 1 word yumi'd, flush -> host_rx_data_o shows word 0 again and vacancy is unchanged.
- Backpressure: mc_tx_ready_i = 0 for 10 cycles with packet valid -> data stable, host_tx_ready_o = 0 throughout, and the packet is delivered exactly once.
- Async reset: assert reset_n_i mid-packet between clock edges -> outputs take reset values immediately, with rx_vacancy_o = 4.
